alu_seq_flags: RTL and testbench

- Parametrised, registered successor to the combinational 8-bit ALU.
- Adds Z80 flag generation (S, Z, H, P/V, N, C), carry-in for ADC/SBC, and multi-cycle shift/rotate-by-N executed one bit per cycle.
- Uses valid/ready handshakes on both sides.
- Sits between the decoder/register file and the writeback path; the decoder supplies A, B, carry-in and the opcode, and writeback consumes the result and the F-register image.

---
 rtl/alu_seq_flags_if.sv | 35 +++
 rtl/alu_seq_flags.sv | 192 +++++++++++++++++++
 tb/tb_alu_seq_flags.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_flags_if.sv
// ---------------------------------------------------------------------------
// alu_seq_flags_if
// Handshake bundle between the decoder/register file (master) and the
// sequential flag ALU (slave). The slave also drives the result side that
// writeback consumes.
//   in_valid/in_ready   : operation offer / acceptance
//   a, b, carry_in      : operands, shift count in b[CW-1:0], current C flag
//   opcode              : operation select (0..E, F reserved)
//   out_valid/out_ready : result held valid / consumer takes it
//   out, flags          : result and F-register image (S Z 0 H 0 P/V N C)
// ---------------------------------------------------------------------------
interface alu_seq_flags_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic [3:0]       opcode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic [7:0]       flags;

   modport master (
      output in_valid, a, b, carry_in, opcode, out_ready,
      input  in_ready, out_valid, out, flags
   );

   modport slave (
      input  in_valid, a, b, carry_in, opcode, out_ready,
      output in_ready, out_valid, out, flags
   );
endinterface

// File: rtl/alu_seq_flags.sv
// ---------------------------------------------------------------------------
// alu_seq_flags
// Registered ALU with Z80-style flag generation. Arithmetic/logic ops finish
// one cycle after acceptance; shifts/rotates by k>0 walk one bit per cycle
// and finish k+1 cycles after acceptance. The result is held until consumed.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_flags_if.slave (operand side and result side handshakes)
// ---------------------------------------------------------------------------
module alu_seq_flags #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input logic            clk,
   input logic            rst_n,
   alu_seq_flags_if.slave bus
);

   localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3,
                          OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_CP  = 4'h7,
                          OP_INC = 4'h8, OP_DEC = 4'h9, OP_RLC = 4'hA, OP_RRC = 4'hB,
                          OP_SLA = 4'hC, OP_SRA = 4'hD, OP_SRL = 4'hE;

   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   function automatic logic ovf_add(input logic signed [WIDTH-1:0] x,
                                    input logic signed [WIDTH-1:0] y,
                                    input logic signed [WIDTH-1:0] r);
      return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
   endfunction

   function automatic logic ovf_sub(input logic signed [WIDTH-1:0] x,
                                    input logic signed [WIDTH-1:0] y,
                                    input logic signed [WIDTH-1:0] r);
      return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
   endfunction

   // S and Z come from sz, which differs from the output only for CP.
   function automatic logic [7:0] pack_flags(input logic [WIDTH-1:0] sz,
                                             input logic h, input logic v,
                                             input logic n, input logic c);
      return {sz[WIDTH-1], ~|sz, 1'b0, h, 1'b0, v, n, c};
   endfunction

   // Returns {result, flags} for every single-cycle path, including count-0 shifts.
   function automatic logic [WIDTH+7:0] alu_calc(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic ci);
      logic [WIDTH:0]   s;
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] sz;
      logic             fh, fv, fn, fc, cc, rsv;
      s = '0; r = '0; fh = 1'b0; fv = 1'b0; fn = 1'b0; fc = 1'b0; cc = 1'b0; rsv = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            cc = (op == OP_ADC) && ci;
            s  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cc};
            r  = s[WIDTH-1:0];
            // carry into bit 4 recovered from the sum bits
            fh = x[4] ^ y[4] ^ r[4];
            fv = ovf_add(x, y, r);
            fc = s[WIDTH];
         end
         OP_SUB, OP_SBC, OP_CP: begin
            cc = (op == OP_SBC) && ci;
            s  = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, cc};
            r  = s[WIDTH-1:0];
            fh = x[4] ^ y[4] ^ r[4];
            fv = ovf_sub(x, y, r);
            fn = 1'b1;
            fc = s[WIDTH];
         end
         OP_AND: begin r = x & y; fh = 1'b1; fv = ~^r; end
         OP_OR:  begin r = x | y; fv = ~^r; end
         OP_XOR: begin r = x ^ y; fv = ~^r; end
         OP_INC: begin
            r  = x + ONE;
            fh = &x[3:0];
            fv = (x == MAX_POS);
            fc = ci;
         end
         OP_DEC: begin
            r  = x - ONE;
            fh = ~|x[3:0];
            fv = (x == MIN_NEG);
            fn = 1'b1;
            fc = ci;
         end
         OP_RLC, OP_RRC, OP_SLA, OP_SRA, OP_SRL: begin
            r  = x;
            fv = ~^r;
            fc = ci;
         end
         default: rsv = 1'b1;
      endcase
      // CP reports the difference in S/Z but passes A through
      sz = r;
      if (op == OP_CP) r = x;
      if (rsv) return '0;
      return {r, pack_flags(sz, fh, fv, fn, fc)};
   endfunction

   // One bit position of a shift/rotate: returns {bit shifted out, new value}.
   function automatic logic [WIDTH:0] shift_step(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] v);
      logic [WIDTH:0] res;
      case (op)
         OP_RLC:  res = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
         OP_RRC:  res = {v[0], v[0], v[WIDTH-1:1]};
         OP_SLA:  res = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
         OP_SRA:  res = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
         default: res = {v[0], 1'b0, v[WIDTH-1:1]};
      endcase
      return res;
   endfunction

   state_t           r_state;
   logic [WIDTH-1:0] r_out;
   logic [7:0]       r_flags;
   logic [WIDTH-1:0] r_val;
   logic [CW-1:0]    r_cnt;
   logic [3:0]       r_op;

   logic             w_ready;
   logic             w_accept;
   logic             w_is_shift;
   logic [CW-1:0]    w_cnt;
   logic [WIDTH+7:0] w_res;
   logic [WIDTH:0]   w_step;

   assign w_ready    = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
   assign w_accept   = bus.in_valid && w_ready;
   assign w_cnt      = bus.b[CW-1:0];
   assign w_is_shift = (bus.opcode >= OP_RLC) && (bus.opcode <= OP_SRL);
   assign w_res      = alu_calc(bus.opcode, bus.a, bus.b, bus.carry_in);
   assign w_step     = shift_step(r_op, r_val);

   assign bus.in_ready  = w_ready;
   assign bus.out_valid = (r_state == DONE);
   assign bus.out       = r_out;
   assign bus.flags     = r_flags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_out   <= '0;
         r_flags <= '0;
         r_val   <= '0;
         r_cnt   <= '0;
         r_op    <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  if (w_is_shift && (w_cnt != '0)) begin
                     r_state <= SHIFT;
                     r_val   <= bus.a;
                     r_cnt   <= w_cnt;
                     r_op    <= bus.opcode;
                  end else begin
                     r_state <= DONE;
                     r_out   <= w_res[WIDTH+7:8];
                     r_flags <= w_res[7:0];
                  end
               end else if ((r_state == DONE) && bus.out_ready) begin
                  r_state <= IDLE;
               end
            end
            SHIFT: begin
               r_val <= w_step[WIDTH-1:0];
               r_cnt <= r_cnt - CNT_ONE;
               // last bit position: publish the result with the final carry
               if (r_cnt == CNT_ONE) begin
                  r_state <= DONE;
                  r_out   <= w_step[WIDTH-1:0];
                  r_flags <= pack_flags(w_step[WIDTH-1:0], 1'b0, ~^w_step[WIDTH-1:0],
                                        1'b0, w_step[WIDTH]);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_flags.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_flags
// Directed vector table for alu_seq_flags plus hand-written sequences for
// back-pressure and asynchronous reset during a multi-cycle shift.
// ---------------------------------------------------------------------------
module tb_alu_seq_flags;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   alu_seq_flags_if #(.WIDTH(8)) bus ();

   alu_seq_flags #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] eo;
      logic [7:0] ef;
      int         lat;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic run_op(input int idx, input vec_t v,
                         output logic [7:0] o, output logic [7:0] f, output int lat);
      @(negedge clk);
      bus.opcode    = v.op;
      bus.a         = v.a;
      bus.b         = v.b;
      bus.carry_in  = v.cin;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      #1 check("in_ready_idle", idx, bus.in_ready, 1);
      @(posedge clk);
      #1;
      // changes after the accept edge must not affect the result
      bus.in_valid = 1'b0;
      bus.a        = ~v.a;
      bus.b        = ~v.b;
      bus.carry_in = ~v.cin;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         if (bus.out_valid) begin
            lat = i;
            break;
         end
         @(posedge clk);
         #1;
      end
      o = bus.out;
      f = bus.flags;
      @(negedge clk) bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   logic [7:0] o, f;
   int         lat;
   int         seen;

   initial begin
      //           op     a      b      cin   out    flags  lat
      vecs[0]  = '{4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h94, 1};  // ADD
      vecs[1]  = '{4'h2, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h93, 1};  // SUB
      vecs[2]  = '{4'h7, 8'h42, 8'h42, 1'b0, 8'h42, 8'h42, 1};  // CP
      vecs[3]  = '{4'h8, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h51, 1};  // INC
      vecs[4]  = '{4'h1, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h51, 1};  // ADC
      vecs[5]  = '{4'hA, 8'h81, 8'h03, 1'b0, 8'h0C, 8'h04, 4};  // RLC 3
      vecs[6]  = '{4'hD, 8'h80, 8'h07, 1'b0, 8'hFF, 8'h84, 8};  // SRA 7
      vecs[7]  = '{4'h3, 8'h10, 8'h01, 1'b1, 8'h0E, 8'h12, 1};  // SBC
      vecs[8]  = '{4'h4, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h14, 1};  // AND
      vecs[9]  = '{4'h5, 8'h01, 8'h02, 1'b1, 8'h03, 8'h04, 1};  // OR
      vecs[10] = '{4'h6, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h44, 1};  // XOR
      vecs[11] = '{4'h9, 8'h80, 8'h00, 1'b0, 8'h7F, 8'h16, 1};  // DEC overflow
      vecs[12] = '{4'h9, 8'h01, 8'h00, 1'b1, 8'h00, 8'h43, 1};  // DEC to zero
      vecs[13] = '{4'hC, 8'h81, 8'h01, 1'b0, 8'h02, 8'h01, 2};  // SLA 1
      vecs[14] = '{4'hE, 8'h81, 8'h02, 1'b1, 8'h20, 8'h00, 3};  // SRL 2
      vecs[15] = '{4'hB, 8'h01, 8'h01, 1'b0, 8'h80, 8'h81, 2};  // RRC 1
      vecs[16] = '{4'hA, 8'h55, 8'h08, 1'b1, 8'h55, 8'h05, 1};  // RLC count 0
      vecs[17] = '{4'hF, 8'h12, 8'h34, 1'b1, 8'h00, 8'h00, 1};  // reserved
      vecs[18] = '{4'h0, 8'h80, 8'h80, 1'b1, 8'h00, 8'h45, 1};  // ADD ignores cin
      vecs[19] = '{4'h8, 8'h7F, 8'h00, 1'b0, 8'h80, 8'h94, 1};  // INC overflow

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.carry_in  = 1'b0;
      bus.opcode    = '0;

      // reset state
      #2 rst_n = 1'b0;
      #12;
      check("rst_in_ready", 0, bus.in_ready, 1);
      check("rst_out_valid", 0, bus.out_valid, 0);
      check("rst_out", 0, bus.out, 0);
      check("rst_flags", 0, bus.flags, 0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         run_op(i, vecs[i], o, f, lat);
         check("out", i, o, vecs[i].eo);
         check("flags", i, f, vecs[i].ef);
         check("latency", i, lat, vecs[i].lat);
      end

      // back-pressure: result held while out_ready=0, new op offered but refused
      @(negedge clk);
      bus.opcode = 4'h0; bus.a = 8'h7F; bus.b = 8'h01; bus.carry_in = 1'b0;
      bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.opcode = 4'h2; bus.a = 8'h00; bus.b = 8'h01;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_out_valid", c, bus.out_valid, 1);
         check("bp_out", c, bus.out, 8'h80);
         check("bp_flags", c, bus.flags, 8'h94);
         check("bp_in_ready", c, bus.in_ready, 0);
      end
      @(negedge clk) bus.out_ready = 1'b1;
      #1 check("bp_in_ready_release", 0, bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("bp_next_valid", 0, bus.out_valid, 1);
      check("bp_next_out", 0, bus.out, 8'hFF);
      check("bp_next_flags", 0, bus.flags, 8'h93);
      @(posedge clk);
      #1;
      check("bp_consumed", 0, bus.out_valid, 0);
      bus.out_ready = 1'b0;

      // asynchronous reset in the middle of a 5-step rotate
      @(negedge clk);
      bus.opcode = 4'hB; bus.a = 8'h21; bus.b = 8'h05; bus.carry_in = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mr_out_valid", 0, bus.out_valid, 0);
      check("mr_out", 0, bus.out, 0);
      check("mr_flags", 0, bus.flags, 0);
      check("mr_in_ready", 0, bus.in_ready, 1);
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      check("mr_no_completion", 0, seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
